recurrence_gen: RTL and testbench

Parametrised successor to the team's single-sequence Fibonacci FSMD. It computes the n-th term of one of four second/third-order integer recurrences (Fibonacci, Lucas, Tribonacci, Pell), selected per request. Output width is independent of the index width. Overflow is detected and the result saturated, and a running computation can be aborted. It is a start/done/rdy compute slave for control FSMs and test sequencers in the prototyping designs.

---
 rtl/recurrence_gen.sv | 143 ++++++++++++++
 tb/tb_recurrence_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/recurrence_gen.sv
// rtl/recurrence_gen.sv - n-th term of Fibonacci/Lucas/Tribonacci/Pell with saturation and abort
module recurrence_gen #(
    parameter int IN_WIDTH  = 6,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [IN_WIDTH-1:0]  n,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 ovf,
    output logic                 done,
    output logic                 rdy
);

    localparam int SW = OUT_WIDTH + 2;

    localparam logic [1:0] M_FIB   = 2'd0;
    localparam logic [1:0] M_LUCAS = 2'd1;
    localparam logic [1:0] M_TRIB  = 2'd2;
    localparam logic [1:0] M_PELL  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            mode_q;
    logic [IN_WIDTH-1:0]   cnt;
    logic [OUT_WIDTH-1:0]  r0, r1, r2;
    logic                  o0, o1, o2;
    logic [OUT_WIDTH-1:0]  s0, s1, s2;
    logic [SW-1:0]         sum;
    logic                  ops_ovf;
    logic                  onext;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_CALC;
            S_CALC: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (cnt == '0)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rdy  = (state == S_IDLE);
        done = (state == S_DONE);
    end

    always_comb begin
        s0 = '0;
        s1 = OUT_WIDTH'(1);
        s2 = OUT_WIDTH'(1);
        case (mode)
            M_FIB:   begin s0 = '0;            s1 = OUT_WIDTH'(1); s2 = OUT_WIDTH'(1); end
            M_LUCAS: begin s0 = OUT_WIDTH'(2); s1 = OUT_WIDTH'(1); s2 = OUT_WIDTH'(3); end
            M_TRIB:  begin s0 = '0;            s1 = '0;            s2 = OUT_WIDTH'(1); end
            M_PELL:  begin s0 = '0;            s1 = OUT_WIDTH'(1); s2 = OUT_WIDTH'(2); end
            default: begin s0 = '0;            s1 = OUT_WIDTH'(1); s2 = OUT_WIDTH'(1); end
        endcase
    end

    // Overflow rides along with each window slot so a term only flags once it reaches r0.
    always_comb begin
        sum     = '0;
        ops_ovf = 1'b0;
        case (mode_q)
            M_TRIB: begin
                sum     = SW'(r0) + SW'(r1) + SW'(r2);
                ops_ovf = o0 | o1 | o2;
            end
            M_PELL: begin
                sum     = (SW'(r2) << 1) + SW'(r1);
                ops_ovf = o1 | o2;
            end
            default: begin
                sum     = SW'(r1) + SW'(r2);
                ops_ovf = o1 | o2;
            end
        endcase
        onext = (|sum[SW-1:OUT_WIDTH]) | ops_ovf;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mode_q <= '0;
            cnt    <= '0;
            r0     <= '0;
            r1     <= '0;
            r2     <= '0;
            o0     <= 1'b0;
            o1     <= 1'b0;
            o2     <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                mode_q <= mode;
                cnt    <= n;
                r0     <= s0;
                r1     <= s1;
                r2     <= s2;
                o0     <= 1'b0;
                o1     <= 1'b0;
                o2     <= 1'b0;
            end else if (state == S_CALC && !abort) begin
                if (cnt == '0) begin
                    result <= o0 ? '1 : r0;
                    ovf    <= o0;
                end else begin
                    r0  <= r1;
                    r1  <= r2;
                    r2  <= sum[OUT_WIDTH-1:0];
                    o0  <= o1;
                    o1  <= o2;
                    o2  <= onext;
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_recurrence_gen.sv
// tb/tb_recurrence_gen.sv - randomized scoreboard bench for recurrence_gen
module tb_recurrence_gen;

    localparam int IW = 6;
    localparam int OW = 32;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [IW-1:0] n;
    logic [OW-1:0] result;
    logic          ovf;
    logic          done;
    logic          rdy;

    int checks = 0;
    int errors = 0;
    logic [OW:0] exp_q[$];
    logic [OW-1:0] last_res;
    logic          last_ovf;

    recurrence_gen #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .start  (start),
        .abort  (abort),
        .mode   (mode),
        .n      (n),
        .result (result),
        .ovf    (ovf),
        .done   (done),
        .rdy    (rdy)
    );

    always #5 clk = ~clk;

    // Terms are clamped far above 2^OW so that "term >= 2^OW" stays exact without wide math.
    function automatic logic [OW:0] model(input int m, input int idx);
        longint unsigned t[64];
        longint unsigned cap;
        longint unsigned lim;
        cap = 64'd1 << 40;
        lim = 64'd1 << OW;
        case (m)
            0: begin t[0] = 0; t[1] = 1; t[2] = 1; end
            1: begin t[0] = 2; t[1] = 1; t[2] = 3; end
            2: begin t[0] = 0; t[1] = 0; t[2] = 1; end
            default: begin t[0] = 0; t[1] = 1; t[2] = 2; end
        endcase
        for (int k = 3; k < 64; k++) begin
            case (m)
                2:       t[k] = t[k-1] + t[k-2] + t[k-3];
                3:       t[k] = 2 * t[k-1] + t[k-2];
                default: t[k] = t[k-1] + t[k-2];
            endcase
            if (t[k] > cap) t[k] = cap;
        end
        if (t[idx] >= lim)
            return {1'b1, {OW{1'b1}}};
        return {1'b0, t[idx][OW-1:0]};
    endfunction

    initial begin
        logic [OW:0] e;
        forever begin
            @(negedge clk);
            if (arst_n && done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done result=%0h ovf=%0b required=no done", result, ovf);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, result} !== e) begin
                        errors++;
                        $display("FAIL result ovf=%0b result=%0d required ovf=%0b result=%0d",
                                 ovf, result, e[OW], e[OW-1:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_exp(input int m, input int nn, input logic [OW-1:0] er, input logic eo,
                           input bit glitch, input bit with_abort);
        int k;
        bit got;
        k = 0;
        while (!rdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rdy_before_start", OW'(rdy), OW'(1));
        mode  = 2'(m);
        n     = IW'(nn);
        start = 1'b1;
        abort = with_abort;
        exp_q.push_back({eo, er});
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        k   = 0;
        got = 0;
        while (!got && k < nn + 10) begin
            if (glitch) begin
                start = 1'b1;
                mode  = 2'($urandom_range(3, 0));
                n     = IW'($urandom);
            end
            @(negedge clk);
            k++;
            if (done) got = 1;
            else check("rdy_low_busy", OW'(rdy), OW'(0));
        end
        start = 1'b0;
        check("latency", OW'(got ? k : -1), OW'(nn + 2));
        @(negedge clk);
        check("done_width", OW'(done), OW'(0));
        check("rdy_after_done", OW'(rdy), OW'(1));
        last_res = er;
        last_ovf = eo;
    endtask

    task automatic run(input int m, input int nn, input bit glitch);
        logic [OW:0] e;
        e = model(m, nn);
        run_exp(m, nn, e[OW-1:0], e[OW], glitch, 1'b0);
    endtask

    initial begin
        arst_n = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        mode   = '0;
        n      = '0;
        repeat (2) @(negedge clk);
        check("reset_result", result, '0);
        check("reset_ovf", OW'(ovf), OW'(0));
        check("reset_done", OW'(done), OW'(0));
        check("reset_rdy", OW'(rdy), OW'(1));
        arst_n = 1'b1;
        @(negedge clk);

        run_exp(0, 10, 32'd55, 1'b0, 1'b0, 1'b0);
        run_exp(1, 0, 32'd2, 1'b0, 1'b0, 1'b0);
        run_exp(1, 1, 32'd1, 1'b0, 1'b0, 1'b0);
        run_exp(3, 5, 32'd29, 1'b0, 1'b0, 1'b0);
        run_exp(2, 10, 32'd81, 1'b0, 1'b1, 1'b0);
        run_exp(0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
        run_exp(1, 5, 32'd11, 1'b0, 1'b0, 1'b1);
        run_exp(0, 47, 32'd2971215073, 1'b0, 1'b0, 1'b0);
        run_exp(0, 48, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);

        // Abort Fib n=20 on its 5th CALC cycle.
        mode  = 2'd0;
        n     = IW'(20);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_rdy", OW'(rdy), OW'(1));
        check("abort_done", OW'(done), OW'(0));
        check("abort_result_kept", result, last_res);
        check("abort_ovf_kept", OW'(ovf), OW'(last_ovf));
        run_exp(3, 3, 32'd5, 1'b0, 1'b0, 1'b0);

        run(3, 63, 1'b0);
        run(2, 63, 1'b0);

        // Reset in the middle of a computation.
        mode  = 2'd0;
        n     = IW'(30);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("midreset_result", result, '0);
        check("midreset_ovf", OW'(ovf), OW'(0));
        check("midreset_rdy", OW'(rdy), OW'(1));
        check("midreset_done", OW'(done), OW'(0));
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            run(int'($urandom_range(3, 0)), int'($urandom_range(63, 0)), bit'($urandom_range(1, 0)));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", OW'(exp_q.size()), OW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
